fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's show-ahead FIFO (empty flag plus data valid while not empty; a read pops and the next entry or empty appears one cycle later).
- Drains entries into a valid/ready stream and groups beats into fixed-length packets with a last flag.
- A two-entry output stage (main plus skid) gives full throughput without a combinational path from m_ready_i to fifo_read_o.
- Sits between the allocator's request FIFOs and downstream stream consumers.

Parameters:
- DATA_W, 16, width of FIFO entries and stream data.
- PKT_LEN, 4, beats per packet; legal range 1..65535.
- CNT_W, 16, width of the packet and stall counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- enable_i  input  1  permits popping from the FIFO.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_data_i  input  DATA_W  FIFO head entry; valid when fifo_empty_i=0.
- fifo_read_o  output  1  pop request to FIFO.
- m_valid_o  output  1  stream data valid.
- m_ready_i  input  1  stream sink ready.
- m_data_o  output  DATA_W  stream data.
- m_last_o  output  1  final beat of the current packet.
- pkt_count_o  output  CNT_W  completed packets.
- stall_count_o  output  CNT_W  stall cycles (Optional Feature).

Behaviour:
- Reset is asynchronous active-low. All state is cleared:
  - state EMPTY.
  - m_valid_o=0, m_data_o=0, m_last_o=0.
  - beat counter 0, pkt_count_o=0, stall_count_o=0.
  - fifo_read_o=0 while rst_ni=0.
- Pop condition: fifo_read_o = enable_i & ~fifo_empty_i & (state != FULL).
  - fifo_read_o is combinational from fifo_empty_i and registered state only; it never depends on m_ready_i.
- Pop data: fifo_data_i is sampled in the same cycle fifo_read_o=1. Latency from FIFO head to m_valid_o is one cycle.
- Handshake: a beat transfers when m_valid_o & m_ready_i.
  - m_data_o and m_last_o hold stable while m_valid_o=1 and m_ready_i=0.
  - m_valid_o never drops without a transfer, except on reset.
- State EMPTY (no data held):
  - pop -> data into main register, go to ONE.
- State ONE (main register valid, m_valid_o=1):
  - transfer and pop -> main loads popped data, stay in ONE.
  - transfer without pop -> EMPTY.
  - pop without transfer -> popped data into skid register, go to FULL.
  - neither -> stay in ONE.
- State FULL (main and skid valid, no pop):
  - transfer -> skid moves to main, go to ONE.
  - otherwise stay in FULL.
- Beat counter (range 0..PKT_LEN-1):
  - increments on each transfer and wraps to 0 after PKT_LEN-1.
  - m_last_o = m_valid_o & (beat == PKT_LEN-1).
  - PKT_LEN=1: m_last_o=1 on every valid beat.
- pkt_count_o increments on a transfer with m_last_o=1 and wraps modulo 2^CNT_W.
- enable_i=0 blocks new pops only. Buffered beats still drain, and the beat counter is not reset, so packets resume mid-packet when enable_i returns.
- Reset mid-packet discards buffered beats and restarts at beat 0.
- Throughput: with m_ready_i held 1 and the FIFO never empty, one beat transfers per cycle.

Optional Feature:
- Macro: FIFO_READER_STALL_CNT_EN.
- Defined:
  - stall_count_o increments each cycle with m_valid_o=1 and m_ready_i=0.
  - saturates at 2^CNT_W-1.
  - cleared only by reset.
- Undefined: stall_count_o is tied to 0 and no counter logic is generated.

Test Plan:
- Reset: assert rst_ni=0 asynchronously mid-cycle with fifo_empty_i=0 -> fifo_read_o=0 and m_valid_o=0 immediately; after release, pkt_count_o=0.
- Streaming: FIFO preloaded with 8 entries 0x0001..0x0008, enable_i=1, m_ready_i=1, PKT_LEN=4 -> 8 consecutive transfers in order; m_last_o on 0x0004 and 0x0008; pkt_count_o=2.
- Backpressure: m_ready_i=0 for 5 cycles with FIFO non-empty -> exactly 2 pops (state FULL), fifo_read_o=0 afterwards, m_data_o stable; on m_ready_i=1, data arrives in order with no loss or duplication.
- Enable gating: 3 entries, enable_i=0 -> no pops. Set enable_i=1 for one pop, then 0 -> one beat delivered, beat counter=1. Re-enable -> remaining beats are beats 2 and 3 of the packet.
- Wrap and PKT_LEN=1: PKT_LEN=1, pkt_count_o forced near 0xFFFF through 2 transfers -> m_last_o=1 on every beat; pkt_count_o goes 0xFFFF -> 0x0000.
- Stall counter (FIFO_READER_STALL_CNT_EN defined): m_valid_o=1 with m_ready_i=0 for 10 cycles -> stall_count_o=10. With the macro undefined -> stall_count_o stays 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a show-ahead FIFO into a valid/ready stream and groups beats into
// fixed-length packets flagged with m_last_o. A main + skid register pair
// keeps full throughput while the pop request depends only on registered
// state and the FIFO empty flag, never on m_ready_i.
//
// Valid/ready contract: a beat transfers on a rising edge where
// m_valid_o & m_ready_i. Once m_valid_o is high, m_valid_o, m_data_o and
// m_last_o stay unchanged until that beat transfers (reset excepted).
//
// Optional feature macro: FIFO_READER_STALL_CNT_EN
//   defined   -> stall_count_o counts cycles with m_valid_o & ~m_ready_i,
//                saturating at all-ones, cleared only by reset.
//   undefined -> stall_count_o is tied to zero.
//
// dbg_state_o exposes the output-stage state (0 EMPTY, 1 ONE, 2 FULL).
`timescale 1ns/1ps

module fifo_stream_reader #(
  parameter int DATA_W  = 16,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_read_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [CNT_W-1:0]  pkt_count_o,
  output logic [CNT_W-1:0]  stall_count_o,
  output logic [1:0]        dbg_state_o
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic [BEAT_W-1:0]   r_beat;
  logic [CNT_W-1:0]    r_pkt;
  logic                w_pop;
  logic                w_valid;
  logic                w_xfer;
  logic                w_last;

  // Pop is gated by rst_ni so the FIFO is never popped while held in reset.
  assign w_valid = (r_state != ST_EMPTY);
  assign w_pop   = rst_ni & enable_i & ~fifo_empty_i & (r_state != ST_FULL);
  assign w_xfer  = w_valid & m_ready_i;
  assign w_last  = w_valid & (r_beat == LAST_BEAT);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic for the two-entry output stage.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_pop) w_state_nxt = ST_ONE;
      end
      ST_ONE: begin
        if (w_xfer && !w_pop)      w_state_nxt = ST_EMPTY;
        else if (!w_xfer && w_pop) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (w_xfer) w_state_nxt = ST_ONE;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Output decode: everything visible comes from registers or the pop term.
  always_comb begin
    fifo_read_o = w_pop;
    m_valid_o   = w_valid;
    m_data_o    = r_main;
    m_last_o    = w_last;
    dbg_state_o = r_state;
    pkt_count_o = r_pkt;
  end

  // Data path: main holds the presented beat, skid catches a pop that
  // arrives while the main beat is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_pop) r_main <= fifo_data_i;
        end
        ST_ONE: begin
          if (w_pop) begin
            if (w_xfer) r_main <= fifo_data_i;
            else        r_skid <= fifo_data_i;
          end
        end
        ST_FULL: begin
          if (w_xfer) r_main <= r_skid;
        end
        default: begin
        end
      endcase
    end
  end

  // Beat position within the packet; advances only on transfers so a
  // disabled reader resumes mid-packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat <= '0;
    end else if (w_xfer) begin
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
    end
  end

  // Completed-packet counter, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pkt <= '0;
    end else if (w_xfer && w_last) begin
      r_pkt <= r_pkt + CNT_W'(1);
    end
  end

`ifdef FIFO_READER_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall;

  // Saturating count of cycles where a beat is offered but not taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall <= '0;
    end else if (w_valid && !m_ready_i && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign stall_count_o = r_stall;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a show-ahead FIFO model feeds the DUT, every
// pushed entry is queued as an expected beat and checked when it transfers.
// A second instance (PKT_LEN=1, CNT_W=4) covers per-beat last and counter wrap.
`timescale 1ns/1ps

module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int PL = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_ni;
  logic          enable_i;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_read_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic [15:0]   pkt_count_o;
  logic [15:0]   stall_count_o;
  logic [1:0]    dbg_state_o;

  logic          en1;
  logic          ready1;
  logic          fifo1_empty;
  logic [DW-1:0] src1;
  logic          fifo1_read;
  logic          valid1;
  logic [DW-1:0] data1;
  logic          last1;
  logic [3:0]    pkt1;
  logic [3:0]    stall1;
  logic [1:0]    dbg1;

  fifo_stream_reader #(.DATA_W(DW), .PKT_LEN(PL), .CNT_W(16)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_read_o(fifo_read_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_last_o(m_last_o), .pkt_count_o(pkt_count_o),
    .stall_count_o(stall_count_o), .dbg_state_o(dbg_state_o)
  );

  fifo_stream_reader #(.DATA_W(DW), .PKT_LEN(1), .CNT_W(4)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(en1),
    .fifo_empty_i(fifo1_empty), .fifo_data_i(src1),
    .fifo_read_o(fifo1_read), .m_valid_o(valid1), .m_ready_i(ready1),
    .m_data_o(data1), .m_last_o(last1), .pkt_count_o(pkt1),
    .stall_count_o(stall1), .dbg_state_o(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_beat;
  int            n_pop;
  int            n_xfer;
  int            n1;
  logic [DW-1:0] exp1;
  logic          hold_prev;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  // ---------------- driver tasks ----------------
  task automatic set_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_entry(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    set_fifo();
  endtask

  // One clock: sample at negedge, score transfers, then update FIFO models
  // just after the rising edge.
  task automatic cycle();
    logic          p0;
    logic          p1;
    logic          exp_last;
    logic [DW-1:0] e;
    @(negedge clk_i);
    p0 = fifo_read_o;
    p1 = fifo1_read;
    if (hold_prev) begin
      total++;
      if (m_valid_o !== 1'b1 || m_data_o !== hold_data || m_last_o !== hold_last) begin
        bad++;
        $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 m_valid_o, m_data_o, m_last_o, hold_data, hold_last);
      end
    end
    if (p0) begin
      total++;
      if (fifo_q.size() == 0) begin
        bad++;
        $display("FAIL pop_empty: fifo_read_o=1 while FIFO model empty, required 0");
      end
    end
    if (m_valid_o && m_ready_i) begin
      total++;
      exp_last = (exp_beat == PL - 1);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra_beat: data=%h, required no beat", m_data_o);
      end else begin
        e = exp_q.pop_front();
        if (m_data_o !== e || m_last_o !== exp_last) begin
          bad++;
          $display("FAIL beat: data=%h last=%b, required data=%h last=%b",
                   m_data_o, m_last_o, e, exp_last);
        end
      end
      exp_beat = (exp_beat == PL - 1) ? 0 : exp_beat + 1;
      n_xfer++;
    end
    hold_prev = m_valid_o & ~m_ready_i;
    hold_data = m_data_o;
    hold_last = m_last_o;
    if (valid1 && ready1) begin
      total++;
      if (last1 !== 1'b1 || data1 !== exp1 || pkt1 !== 4'(n1)) begin
        bad++;
        $display("FAIL len1_beat: data=%h last=%b pkt=%0d, required data=%h last=1 pkt=%0d",
                 data1, last1, pkt1, exp1, 4'(n1));
      end
      exp1 = exp1 + 1'b1;
      n1++;
    end
    @(posedge clk_i);
    #1;
    if (p0) begin
      n_pop++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      set_fifo();
    end
    if (p1) src1 = src1 + 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    push_entry(16'h00A1);
    push_entry(16'h00A2);
    push_entry(16'h00A3);
    enable_i  = 1'b1;
    m_ready_i = 1'b0;
    cycle();
    cycle();
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if (fifo_read_o !== 1'b0 || m_valid_o !== 1'b0 || fifo_empty_i !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: read=%b valid=%b empty_in=%b, required read=0 valid=0 empty_in=0",
               fifo_read_o, m_valid_o, fifo_empty_i);
    end
    total++;
    if (m_data_o !== '0 || m_last_o !== 1'b0 || dbg_state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs: data=%h last=%b state=%0d, required 0 0 0",
               m_data_o, m_last_o, dbg_state_o);
    end
    fifo_q.delete();
    exp_q.delete();
    set_fifo();
    enable_i  = 1'b0;
    exp_beat  = 0;
    hold_prev = 1'b0;
    n1        = 0;
    exp1      = src1;
    en1       = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    #1;
    total++;
    if (pkt_count_o !== 16'd0 || stall_count_o !== 16'd0 || pkt1 !== 4'd0) begin
      bad++;
      $display("FAIL reset_counts: pkt=%0d stall=%0d pkt1=%0d, required 0 0 0",
               pkt_count_o, stall_count_o, pkt1);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) push_entry(DW'(i));
    enable_i  = 1'b1;
    m_ready_i = 1'b1;
    n_xfer    = 0;
    repeat (9) cycle();
    total++;
    if (n_xfer !== 8 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stream_rate: transfers=%0d left=%0d, required 8 0", n_xfer, exp_q.size());
    end
    total++;
    if (pkt_count_o !== 16'd2) begin
      bad++;
      $display("FAIL stream_pkt: pkt=%0d, required 2", pkt_count_o);
    end
  endtask

  task automatic test_enable_gating();
    enable_i  = 1'b0;
    m_ready_i = 1'b1;
    push_entry(16'h0021);
    push_entry(16'h0022);
    push_entry(16'h0023);
    n_pop = 0;
    repeat (3) cycle();
    total++;
    if (n_pop !== 0 || m_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL gate_off: pops=%0d valid=%b, required 0 0", n_pop, m_valid_o);
    end
    enable_i = 1'b1;
    cycle();
    enable_i = 1'b0;
    n_xfer   = 0;
    repeat (3) cycle();
    total++;
    if (n_pop !== 1 || n_xfer !== 1) begin
      bad++;
      $display("FAIL gate_one: pops=%0d transfers=%0d, required 1 1", n_pop, n_xfer);
    end
    enable_i = 1'b1;
    push_entry(16'h0024);
    n_xfer = 0;
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) cycle();
    total++;
    if (n_xfer !== 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL gate_resume: transfers=%0d left=%0d, required 3 0", n_xfer, exp_q.size());
    end
    total++;
    if (pkt_count_o !== 16'd3) begin
      bad++;
      $display("FAIL gate_pkt: pkt=%0d, required 3", pkt_count_o);
    end
  endtask

  task automatic test_backpressure();
    enable_i  = 1'b1;
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push_entry(DW'(16'h0040 + i));
    n_pop = 0;
    repeat (5) cycle();
    total++;
    if (n_pop !== 2 || dbg_state_o !== 2'd2 || fifo_read_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_fill: pops=%0d state=%0d read=%b, required 2 2 0",
               n_pop, dbg_state_o, fifo_read_o);
    end
    total++;
    if (m_data_o !== 16'h0040 || m_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_head: data=%h valid=%b, required 0040 1", m_data_o, m_valid_o);
    end
    m_ready_i = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
    total++;
    if (exp_q.size() != 0 || m_valid_o !== 1'b0 || pkt_count_o !== 16'd4) begin
      bad++;
      $display("FAIL bp_drain: left=%0d valid=%b pkt=%0d, required 0 0 4",
               exp_q.size(), m_valid_o, pkt_count_o);
    end
  endtask

  task automatic test_stall();
    logic [15:0] base;
    logic [15:0] want;
    enable_i  = 1'b1;
    m_ready_i = 1'b0;
    push_entry(16'h0050);
    cycle();
    base = stall_count_o;
    repeat (10) cycle();
`ifdef FIFO_READER_STALL_CNT_EN
    want = base + 16'd10;
`else
    want = 16'd0;
`endif
    total++;
    if (stall_count_o !== want || m_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL stall_cnt: stall=%0d valid=%b, required %0d 1", stall_count_o, m_valid_o, want);
    end
    m_ready_i = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL stall_drain: left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_pkt_len1();
    int cyc;
    logic [3:0] want;
    en1    = 1'b1;
    ready1 = 1'b1;
    cyc    = 0;
    for (int k = 0; k < 40 && n1 < 17; k++) begin
      cycle();
      cyc++;
    end
    total++;
    if (n1 !== 17 || cyc !== 18) begin
      bad++;
      $display("FAIL len1_rate: transfers=%0d cycles=%0d, required 17 18", n1, cyc);
    end
    total++;
    if (pkt1 !== 4'd1) begin
      bad++;
      $display("FAIL len1_wrap: pkt=%0d, required 1", pkt1);
    end
    ready1 = 1'b0;
    repeat (20) cycle();
`ifdef FIFO_READER_STALL_CNT_EN
    want = 4'hF;
`else
    want = 4'h0;
`endif
    total++;
    if (stall1 !== want || dbg1 !== 2'd2) begin
      bad++;
      $display("FAIL len1_stall: stall=%0d state=%0d, required %0d 2", stall1, dbg1, want);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_ni      = 1'b0;
    enable_i    = 1'b0;
    m_ready_i   = 1'b0;
    en1         = 1'b0;
    ready1      = 1'b0;
    fifo1_empty = 1'b0;
    src1        = 16'd0;
    exp1        = 16'd0;
    n1          = 0;
    exp_beat    = 0;
    n_pop       = 0;
    n_xfer      = 0;
    hold_prev   = 1'b0;
    hold_data   = '0;
    hold_last   = 1'b0;
    set_fifo();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    test_reset();
    test_streaming();
    test_enable_gating();
    test_backpressure();
    test_stall();
    test_pkt_len1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
